// File: rtl/cfg_frame_parser.sv
// Byte-stream parser for config frames A5 MOD CMD LEN DATA.. CHK 5A.
// A validated command is presented through a single-entry ready/valid buffer.
//   state   | meaning
//   S_IDLE  | waiting for the A5 start byte
//   S_MOD   | expecting the module ID
//   S_CMD   | expecting the command byte
//   S_LEN   | expecting the payload length
//   S_DATA  | collecting payload bytes
//   S_CHK   | expecting the XOR checksum
//   S_END   | expecting 5A; validate and commit
module cfg_frame_parser #(
  parameter int MAX_LEN        = 4,
  parameter int NUM_MODULES    = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  output logic                         cfg_valid_o,
  input  logic                         cfg_ready_i,
  output logic [7:0]                   cfg_mod_o,
  output logic [7:0]                   cfg_cmd_o,
  output logic [$clog2(MAX_LEN+1)-1:0] cfg_len_o,
  output logic [8*MAX_LEN-1:0]         cfg_data_o,
  output logic                         parse_error_o,
  output logic [2:0]                   err_code_o,
  output logic                         busy_o
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [7:0]    NUM_MOD8 = 8'(NUM_MODULES);

  localparam logic [2:0] E_LEN = 3'd1, E_CHK = 3'd2, E_END = 3'd3,
                         E_TMO = 3'd4, E_OVR = 3'd5, E_MOD = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_MOD, S_CMD, S_LEN, S_DATA, S_CHK, S_END
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic [TW-1:0]       to_cnt_q;
  logic [7:0]          mod_q, cmd_q, chk_q;
  logic [LW-1:0]       len_q, idx_q;
  logic [8*MAX_LEN-1:0] data_q;
  logic                chk_ok_q;
  logic                cfg_valid_q, parse_error_q;
  logic [7:0]          cfg_mod_q, cfg_cmd_q;
  logic [LW-1:0]       cfg_len_q;
  logic [8*MAX_LEN-1:0] cfg_data_q;
  logic [2:0]          err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      to_cnt_q      <= '0;
      mod_q         <= '0;
      cmd_q         <= '0;
      chk_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      chk_ok_q      <= 1'b0;
      cfg_valid_q   <= 1'b0;
      parse_error_q <= 1'b0;
      cfg_mod_q     <= '0;
      cfg_cmd_q     <= '0;
      cfg_len_q     <= '0;
      cfg_data_q    <= '0;
      err_code_q    <= '0;
    end else begin
      parse_error_q <= 1'b0;
      if (cfg_valid_q && cfg_ready_i) cfg_valid_q <= 1'b0;

      if (rx_valid_i) begin
        to_cnt_q <= TO_LOAD;
        case (state_q)
          S_IDLE: begin
            if (rx_data_i == 8'hA5) begin
              state_q <= S_MOD;
              busy_q  <= 1'b1;
              mod_q   <= '0;
              cmd_q   <= '0;
              chk_q   <= '0;
              len_q   <= '0;
              idx_q   <= '0;
              data_q  <= '0;
            end
          end
          S_MOD: begin
            mod_q   <= rx_data_i;
            chk_q   <= chk_q ^ rx_data_i;
            state_q <= S_CMD;
          end
          S_CMD: begin
            cmd_q   <= rx_data_i;
            chk_q   <= chk_q ^ rx_data_i;
            state_q <= S_LEN;
          end
          S_LEN: begin
            if (rx_data_i > MAX_LEN8) begin
              parse_error_q <= 1'b1;
              err_code_q    <= E_LEN;
              state_q       <= S_IDLE;
              busy_q        <= 1'b0;
            end else begin
              len_q   <= rx_data_i[LW-1:0];
              chk_q   <= chk_q ^ rx_data_i;
              state_q <= (rx_data_i == 8'h00) ? S_CHK : S_DATA;
            end
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++)
              if (idx_q == LW'(i)) data_q[8*i +: 8] <= rx_data_i;
            chk_q <= chk_q ^ rx_data_i;
            idx_q <= idx_q + LW'(1);
            if (idx_q + LW'(1) == len_q) state_q <= S_CHK;
          end
          S_CHK: begin
            chk_ok_q <= (rx_data_i == chk_q);
            state_q  <= S_END;
          end
          S_END: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (rx_data_i != 8'h5A) begin
              parse_error_q <= 1'b1;
              err_code_q    <= E_END;
            end else if (!chk_ok_q) begin
              parse_error_q <= 1'b1;
              err_code_q    <= E_CHK;
            end else if (mod_q == 8'h00 || mod_q > NUM_MOD8) begin
              parse_error_q <= 1'b1;
              err_code_q    <= E_MOD;
            end else if (cfg_valid_q && !cfg_ready_i) begin
              // buffer still owned by the consumer: keep the old command
              parse_error_q <= 1'b1;
              err_code_q    <= E_OVR;
            end else begin
              cfg_valid_q <= 1'b1;
              cfg_mod_q   <= mod_q;
              cfg_cmd_q   <= cmd_q;
              cfg_len_q   <= len_q;
              cfg_data_q  <= data_q;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (TIMEOUT_CYCLES != 0 && state_q != S_IDLE) begin
        if (to_cnt_q == '0) begin
          parse_error_q <= 1'b1;
          err_code_q    <= E_TMO;
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
        end else begin
          to_cnt_q <= to_cnt_q - TW'(1);
        end
      end
    end
  end

  assign cfg_valid_o   = cfg_valid_q;
  assign cfg_mod_o     = cfg_mod_q;
  assign cfg_cmd_o     = cfg_cmd_q;
  assign cfg_len_o     = cfg_len_q;
  assign cfg_data_o    = cfg_data_q;
  assign parse_error_o = parse_error_q;
  assign err_code_o    = err_code_q;
  assign busy_o        = busy_q;

endmodule
